rps_match_controller: RTL and testbench
=======================================

Name: rps_match_controller

Overview:
- Sequences a best-of-N rock-paper-scissors match on the iCEBreaker board.
- Synchronises and debounces the three move inputs, generates the computer move, and judges each round. It holds the result on the LEDs for a fixed reveal time, keeps both scores, and declares the match winner.
- Sits between the board buttons/PMOD inputs (already OR-combined to active-high) and the LED1-3 / P1A10-8 outputs.

Parameters:
- ROUNDS_TO_WIN, 2, rounds needed to win the match; legal range 1..7.
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept an input change (10 ms at 12 MHz).
- REVEAL_CYCLES, 12000000, cycles a round result is held (1 s at 12 MHz).
- FLASH_BIT, 20, free-running flash counter bit that toggles the attract pattern.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST_N  in  1  asynchronous active-low reset.
- btn_rock  in  1  active-high, asynchronous to CLK.
- btn_paper  in  1  active-high, asynchronous to CLK.
- btn_scissors  in  1  active-high, asynchronous to CLK.
- leds  out  3  drives {LED1,LED2,LED3} and {P1A10,P1A9,P1A8}.
- person_move  out  2  last accepted person move (1 rock, 2 paper, 3 scissors; 0 none).
- computer_move  out  2  last computer move, same encoding.
- person_score  out  3  person rounds won.
- computer_score  out  3  computer rounds won.
- match_over  out  1  high in MATCH_END.
- person_won_match  out  1  valid while match_over.

Behaviour:
- One clock, CLK. Reset RST_N is asynchronous and active-low. All flops clear on reset.
- Reset values:
  - leds=3'b011.
  - Moves 0, scores 0, match_over=0, person_won_match=0.
  - State IDLE; all counters 0.
- Input path:
  - 2-flop synchroniser on the 3-bit vector {rock,paper,scissors}.
  - Debounce counter clears whenever the synchronised vector differs from the previous cycle; otherwise it increments, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1, the vector is copied to stable_vec.
- Move generator: 2-bit mod-3 counter. 0 after reset, +1 every cycle, wraps 2->0. Computer move = counter value in the accept cycle + 1.
- Flash counter: free-running, 0 after reset.
- Result codes: PERSON_WINS=3'b001, COMPUTER_WINS=3'b010, TIE=3'b100.
- States:
  - IDLE:
    - leds alternate 3'b011 (flash bit 1) / 3'b100 (flash bit 0).
    - Transition when stable_vec != 0 (accept cycle T):
      - Latch person_move with priority rock>paper>scissors if several bits are set.
      - Latch computer_move.
      - Judge the round.
      - Go to REVEAL at T+1.
  - REVEAL:
    - From T+1, leds = result code.
    - The winner's score increments at T+1; a tie changes neither score.
    - Holds exactly REVEAL_CYCLES cycles, then goes to RELEASE.
    - Inputs are ignored; a held button never starts a second round.
  - RELEASE:
    - leds keep the result.
    - Waits for stable_vec == 0.
    - Then goes to MATCH_END if either score == ROUNDS_TO_WIN, else IDLE.
  - MATCH_END:
    - match_over=1; person_won_match = (person_score == ROUNDS_TO_WIN).
    - leds = winner code, gated on and off by the flash bit (off = 3'b000).
    - Leaves on stable_vec != 0 followed by stable_vec == 0 (press and release).
    - On the release cycle: clear scores and moves, set match_over=0, go to IDLE.
- Scores saturate at ROUNDS_TO_WIN, so they never exceed it.
- Reset mid-operation: immediate return to reset values, whatever the state; no partial score survives.
- Input glitches shorter than DEBOUNCE_CYCLES never change stable_vec.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REVEAL_CYCLES=10, ROUNDS_TO_WIN=2, FLASH_BIT=2.
1. Reset, then idle 16 cycles -> leds toggle between 011 and 100 every 4 cycles; scores 0; match_over 0.
2. Glitch: btn_rock high for 3 cycles, then low -> no state change; person_move stays 0.
3. Hold btn_rock with the mod-3 counter at 2 in the accept cycle -> person_move=1, computer_move=3, leds=001 at T+1, person_score=1. leds hold 001 for 10 cycles; release -> IDLE.
4. Hold btn_paper with the counter at 1 -> computer_move=2, leds=100, both scores unchanged. Keep the button held through REVEAL -> no second round until release plus re-press.
5. Computer wins two rounds (scissors vs rock) -> computer_score=2, match_over=1, person_won_match=0, leds flash 010/000. Press and release any button -> scores 0, IDLE.
6. Assert RST_N low mid-REVEAL with person_score=1 -> all outputs return to reset values at once; leds=011.

Source files
------------

// File: rtl/rps_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : rps_match_controller
// Purpose  : Best-of-N rock-paper-scissors match sequencer with debounced moves
// Revision : 1.0
// ============================================================================
module rps_match_controller #(
  parameter int ROUNDS_TO_WIN   = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REVEAL_CYCLES   = 12000000,
  parameter int FLASH_BIT       = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_rock,
  input  logic       btn_paper,
  input  logic       btn_scissors,
  output logic [2:0] leds,
  output logic [1:0] person_move,
  output logic [1:0] computer_move,
  output logic [2:0] person_score,
  output logic [2:0] computer_score,
  output logic       match_over,
  output logic       person_won_match
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REV_W = $clog2(REVEAL_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REV_W-1:0] REV_LAST  = REV_W'(REVEAL_CYCLES - 1);
  localparam logic [2:0]       WIN_SCORE = 3'(ROUNDS_TO_WIN);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REVEAL    = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_MATCH_END = 2'd3;

  localparam logic [2:0] RES_PERSON   = 3'b001;
  localparam logic [2:0] RES_COMPUTER = 3'b010;
  localparam logic [2:0] RES_TIE      = 3'b100;
  localparam logic [2:0] ATTRACT_ON   = 3'b011;
  localparam logic [2:0] ATTRACT_OFF  = 3'b100;

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]       stable_q, stable_d;
  logic [1:0]       mod3_q, mod3_d;
  logic [FLASH_BIT:0] flash_q, flash_d;
  logic [1:0]       state_q, state_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [2:0]       leds_q, leds_d;
  logic [1:0]       person_move_q, person_move_d, computer_move_q, computer_move_d;
  logic [2:0]       person_score_q, person_score_d, computer_score_q, computer_score_d;
  logic             seen_press_q, seen_press_d;

  logic [1:0] pick_move;
  logic [1:0] cpu_move;
  logic [2:0] round_result;

  // Several buttons at once resolve to the highest-priority move.
  always_comb begin
    pick_move = 2'd0;
    if (stable_q[2])      pick_move = 2'd1;
    else if (stable_q[1]) pick_move = 2'd2;
    else if (stable_q[0]) pick_move = 2'd3;
  end

  assign cpu_move = mod3_q + 2'd1;

  always_comb begin
    round_result = RES_COMPUTER;
    if (pick_move == cpu_move)
      round_result = RES_TIE;
    else if ((pick_move == 2'd1 && cpu_move == 2'd3) ||
             (pick_move == 2'd2 && cpu_move == 2'd1) ||
             (pick_move == 2'd3 && cpu_move == 2'd2))
      round_result = RES_PERSON;
  end

  always_comb begin
    sync1_d = {btn_rock, btn_paper, btn_scissors};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    if (sync2_q != prev_q)       deb_cnt_d = '0;
    else if (deb_cnt_q == DEB_LAST) deb_cnt_d = deb_cnt_q;
    else                         deb_cnt_d = deb_cnt_q + 1'b1;

    stable_d = stable_q;
    if (sync2_q == prev_q && deb_cnt_q == DEB_LAST)
      stable_d = sync2_q;

    mod3_d  = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
    flash_d = flash_q + 1'b1;

    state_d          = state_q;
    rev_cnt_d        = rev_cnt_q;
    leds_d           = leds_q;
    person_move_d    = person_move_q;
    computer_move_d  = computer_move_q;
    person_score_d   = person_score_q;
    computer_score_d = computer_score_q;
    seen_press_d     = seen_press_q;

    case (state_q)
      ST_IDLE: begin
        leds_d = flash_q[FLASH_BIT] ? ATTRACT_ON : ATTRACT_OFF;
        if (stable_q != 3'b000) begin
          person_move_d   = pick_move;
          computer_move_d = cpu_move;
          leds_d          = round_result;
          rev_cnt_d       = '0;
          state_d         = ST_REVEAL;
          if (round_result == RES_PERSON && person_score_q != WIN_SCORE)
            person_score_d = person_score_q + 3'd1;
          if (round_result == RES_COMPUTER && computer_score_q != WIN_SCORE)
            computer_score_d = computer_score_q + 3'd1;
        end
      end
      ST_REVEAL: begin
        if (rev_cnt_q == REV_LAST) begin
          rev_cnt_d = '0;
          state_d   = ST_RELEASE;
        end else begin
          rev_cnt_d = rev_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stable_q == 3'b000) begin
          seen_press_d = 1'b0;
          if (person_score_q == WIN_SCORE || computer_score_q == WIN_SCORE)
            state_d = ST_MATCH_END;
          else
            state_d = ST_IDLE;
        end
      end
      ST_MATCH_END: begin
        leds_d = flash_q[FLASH_BIT] ?
                 ((person_score_q == WIN_SCORE) ? RES_PERSON : RES_COMPUTER) : 3'b000;
        // Exit needs a full press-and-release so the last round's button can't end the match.
        if (stable_q != 3'b000) begin
          seen_press_d = 1'b1;
        end else if (seen_press_q) begin
          seen_press_d     = 1'b0;
          person_move_d    = 2'd0;
          computer_move_d  = 2'd0;
          person_score_d   = 3'd0;
          computer_score_d = 3'd0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q          <= 3'b000;
      sync2_q          <= 3'b000;
      prev_q           <= 3'b000;
      deb_cnt_q        <= '0;
      stable_q         <= 3'b000;
      mod3_q           <= 2'd0;
      flash_q          <= '0;
      state_q          <= ST_IDLE;
      rev_cnt_q        <= '0;
      leds_q           <= ATTRACT_ON;
      person_move_q    <= 2'd0;
      computer_move_q  <= 2'd0;
      person_score_q   <= 3'd0;
      computer_score_q <= 3'd0;
      seen_press_q     <= 1'b0;
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      prev_q           <= prev_d;
      deb_cnt_q        <= deb_cnt_d;
      stable_q         <= stable_d;
      mod3_q           <= mod3_d;
      flash_q          <= flash_d;
      state_q          <= state_d;
      rev_cnt_q        <= rev_cnt_d;
      leds_q           <= leds_d;
      person_move_q    <= person_move_d;
      computer_move_q  <= computer_move_d;
      person_score_q   <= person_score_d;
      computer_score_q <= computer_score_d;
      seen_press_q     <= seen_press_d;
    end
  end

  assign leds             = leds_q;
  assign person_move      = person_move_q;
  assign computer_move    = computer_move_q;
  assign person_score     = person_score_q;
  assign computer_score   = computer_score_q;
  assign match_over       = (state_q == ST_MATCH_END);
  assign person_won_match = match_over && (person_score_q == WIN_SCORE);

endmodule
`default_nettype wire

// File: tb/tb_rps_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_controller
// Purpose  : Scoreboard bench for rps_match_controller (small debounce/reveal)
// Revision : 1.0
// ============================================================================
module tb_rps_match_controller;

  localparam int DEB = 4;
  localparam int REV = 10;
  localparam int RTW = 2;
  localparam int FB  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rock = 1'b0, btn_paper = 1'b0, btn_scissors = 1'b0;
  logic [2:0] leds;
  logic [1:0] person_move, computer_move;
  logic [2:0] person_score, computer_score;
  logic       match_over, person_won_match;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [1:0] pm;
    logic [1:0] cm;
    logic [2:0] res;
    logic [2:0] ps;
    logic [2:0] cs;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_ps = 3'd0;
  logic [2:0] exp_cs = 3'd0;

  rps_match_controller #(
    .ROUNDS_TO_WIN  (RTW),
    .DEBOUNCE_CYCLES(DEB),
    .REVEAL_CYCLES  (REV),
    .FLASH_BIT      (FB)
  ) dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .btn_rock        (btn_rock),
    .btn_paper       (btn_paper),
    .btn_scissors    (btn_scissors),
    .leds            (leds),
    .person_move     (person_move),
    .computer_move   (computer_move),
    .person_score    (person_score),
    .computer_score  (computer_score),
    .match_over      (match_over),
    .person_won_match(person_won_match)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; drives the flash and mod-3 models.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] idle_leds(input int n);
    logic [31:0] v;
    v = 32'(n - 1);
    return v[FB] ? 3'b011 : 3'b100;
  endfunction

  function automatic logic [2:0] end_leds(input int n, input logic [2:0] win);
    logic [31:0] v;
    v = 32'(n - 1);
    return v[FB] ? win : 3'b000;
  endfunction

  // A move beats the one that precedes it cyclically: rock>scissors, paper>rock, scissors>paper.
  function automatic logic [2:0] judge(input logic [1:0] p, input logic [1:0] c);
    if (p == c) return 3'b100;
    if ((int'(c) % 3) + 1 == int'(p)) return 3'b001;
    return 3'b010;
  endfunction

  task automatic check_reset_values(input string tag);
    checks++;
    if (leds !== 3'b011 || person_move !== 2'd0 || computer_move !== 2'd0 ||
        person_score !== 3'd0 || computer_score !== 3'd0 ||
        match_over !== 1'b0 || person_won_match !== 1'b0) begin
      errors++;
      $display("FAIL %s: leds=%b pm=%0d cm=%0d ps=%0d cs=%0d mo=%b pw=%b, required leds=011 and all others 0",
               tag, leds, person_move, computer_move, person_score, computer_score,
               match_over, person_won_match);
    end
  endtask

  // Press vec at a cycle chosen so the accept cycle sees mod-3 counter == want_mod.
  task automatic play_round(input logic [2:0] vec, input int want_mod, input int hold_checks);
    int         e;
    exp_t       x;
    logic [1:0] pm, cm;
    while (((cyc + 7) % 3) != want_mod) step(1);
    e = cyc;
    {btn_rock, btn_paper, btn_scissors} = vec;
    pm = vec[2] ? 2'd1 : (vec[1] ? 2'd2 : 2'd3);
    cm = 2'(want_mod + 1);
    x.pm  = pm;
    x.cm  = cm;
    x.res = judge(pm, cm);
    if (x.res == 3'b001 && exp_ps != 3'(RTW)) exp_ps = exp_ps + 3'd1;
    if (x.res == 3'b010 && exp_cs != 3'(RTW)) exp_cs = exp_cs + 3'd1;
    x.ps = exp_ps;
    x.cs = exp_cs;
    sb.push_back(x);
    step(7);
    checks++;
    if (leds !== idle_leds(cyc)) begin
      errors++;
      $display("FAIL pre_accept_leds: got %b, required %b", leds, idle_leds(cyc));
    end
    step(1);
    if (cyc != e + 8 || sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL round_timing: cycle %0d queue %0d, required cycle %0d", cyc, sb.size(), e + 8);
    end else begin
      x = sb.pop_front();
      checks++;
      if (person_move !== x.pm) begin
        errors++; $display("FAIL person_move: got %0d, required %0d", person_move, x.pm);
      end
      checks++;
      if (computer_move !== x.cm) begin
        errors++; $display("FAIL computer_move: got %0d, required %0d", computer_move, x.cm);
      end
      checks++;
      if (leds !== x.res) begin
        errors++; $display("FAIL result_leds: got %b, required %b", leds, x.res);
      end
      checks++;
      if (person_score !== x.ps || computer_score !== x.cs) begin
        errors++;
        $display("FAIL scores: got p=%0d c=%0d, required p=%0d c=%0d",
                 person_score, computer_score, x.ps, x.cs);
      end
      for (int i = 0; i < hold_checks; i++) begin
        step(1);
        checks++;
        if (leds !== x.res) begin
          errors++; $display("FAIL reveal_hold: cycle %0d got %b, required %b", cyc, leds, x.res);
        end
      end
    end
  endtask

  task automatic release_buttons(input logic [2:0] held, input bit to_match_end);
    {btn_rock, btn_paper, btn_scissors} = 3'b000;
    step(7);
    checks++;
    if (leds !== held) begin
      errors++; $display("FAIL release_hold: got %b, required %b", leds, held);
    end
    step(1);
    checks++;
    if (match_over !== to_match_end) begin
      errors++; $display("FAIL release_match_over: got %b, required %b", match_over, to_match_end);
    end
    step(1);
    if (!to_match_end) begin
      checks++;
      if (leds !== idle_leds(cyc)) begin
        errors++; $display("FAIL back_to_idle: got %b, required %b", leds, idle_leds(cyc));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    check_reset_values("reset_released");
    for (int i = 0; i < 16; i++) begin
      step(1);
      checks++;
      if (leds !== idle_leds(cyc) || person_score !== 3'd0 || computer_score !== 3'd0 ||
          match_over !== 1'b0) begin
        errors++;
        $display("FAIL idle_attract: cycle %0d leds=%b ps=%0d cs=%0d mo=%b, required leds=%b scores 0 mo 0",
                 cyc, leds, person_score, computer_score, match_over, idle_leds(cyc));
      end
    end
  endtask

  task automatic test_glitch();
    btn_rock = 1'b1;
    step(3);
    btn_rock = 1'b0;
    step(12);
    checks++;
    if (person_move !== 2'd0 || computer_move !== 2'd0 || leds !== idle_leds(cyc)) begin
      errors++;
      $display("FAIL glitch: pm=%0d cm=%0d leds=%b, required pm=0 cm=0 leds=%b",
               person_move, computer_move, leds, idle_leds(cyc));
    end
  endtask

  task automatic test_person_wins();
    play_round(3'b100, 2, REV - 1);
    release_buttons(3'b001, 1'b0);
  endtask

  task automatic test_tie_held();
    play_round(3'b010, 1, REV - 1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (leds !== 3'b100 || person_score !== exp_ps || computer_score !== exp_cs) begin
        errors++;
        $display("FAIL held_button: leds=%b ps=%0d cs=%0d, required leds=100 ps=%0d cs=%0d",
                 leds, person_score, computer_score, exp_ps, exp_cs);
      end
    end
    release_buttons(3'b100, 1'b0);
    step(6);
    checks++;
    if (person_move !== 2'd2 || sb.size() != 0) begin
      errors++; $display("FAIL no_second_round: pm=%0d queue=%0d, required pm=2 queue=0",
                         person_move, sb.size());
    end
  endtask

  task automatic test_computer_match();
    play_round(3'b001, 0, REV - 1);
    release_buttons(3'b010, 1'b0);
    play_round(3'b001, 0, REV - 1);
    release_buttons(3'b010, 1'b1);
    checks++;
    if (person_won_match !== 1'b0 || computer_score !== 3'(RTW)) begin
      errors++; $display("FAIL match_winner: pw=%b cs=%0d, required pw=0 cs=%0d",
                         person_won_match, computer_score, RTW);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (leds !== end_leds(cyc, 3'b010) || match_over !== 1'b1) begin
        errors++; $display("FAIL match_flash: cycle %0d leds=%b mo=%b, required leds=%b mo=1",
                           cyc, leds, match_over, end_leds(cyc, 3'b010));
      end
      step(1);
    end
    btn_paper = 1'b1;
    step(10);
    btn_paper = 1'b0;
    step(7);
    checks++;
    if (match_over !== 1'b1) begin
      errors++; $display("FAIL match_hold_until_release: mo=%b, required 1", match_over);
    end
    step(1);
    exp_ps = 3'd0;
    exp_cs = 3'd0;
    checks++;
    if (match_over !== 1'b0 || person_score !== 3'd0 || computer_score !== 3'd0 ||
        person_move !== 2'd0 || computer_move !== 2'd0) begin
      errors++;
      $display("FAIL match_clear: mo=%b ps=%0d cs=%0d pm=%0d cm=%0d, required all 0",
               match_over, person_score, computer_score, person_move, computer_move);
    end
    step(1);
    checks++;
    if (leds !== idle_leds(cyc)) begin
      errors++; $display("FAIL match_to_idle: got %b, required %b", leds, idle_leds(cyc));
    end
  endtask

  task automatic test_reset_mid_reveal();
    step(4);
    play_round(3'b100, 2, 4);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_reveal");
    exp_ps = 3'd0;
    exp_cs = 3'd0;
    {btn_rock, btn_paper, btn_scissors} = 3'b000;
    step(2);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (leds !== idle_leds(cyc) || person_score !== 3'd0 || person_move !== 2'd0) begin
      errors++; $display("FAIL after_reset_idle: leds=%b ps=%0d pm=%0d, required leds=%b ps=0 pm=0",
                         leds, person_score, person_move, idle_leds(cyc));
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_person_wins();
    test_tie_held();
    test_computer_match();
    test_reset_mid_reveal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
